// File: rtl/y86_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_mem_pkg
// Description : Shared types and sizing helpers for the unified memory port.
// Revision    : 1.0  initial release
// ============================================================================
package y86_mem_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   function automatic int timer_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Clear/enable cycle counter flagging the last permitted cycle.
// Revision    : 1.0  initial release
// ============================================================================
module mem_timeout_ctr
   import y86_mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expired
);

   localparam int            TW           = timer_w(TIMEOUT);
   localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_count;

   // Saturates at the last cycle so a stalled port can never wrap around.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_en && (r_count != c_TIMER_LAST)) begin
         r_count <= r_count + TW'(1);
      end
   end

   assign o_expired = (r_count == c_TIMER_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fetch/data arbiter for one single-ported memory with timeout.
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import y86_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int TIMEOUT    = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   output logic              i_wait,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              d_wait,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err
);

   localparam int            SW           = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);

   arb_state_e        r_state;
   owner_e            r_owner;
   logic [SW-1:0]     r_starve;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_i_done, r_d_done;
   logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
   logic              r_i_err, r_d_err;

   logic w_grant_fetch;
   logic w_expired;
   logic w_finish;

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (r_state != ST_BUSY),
      .i_en      ((r_state == ST_BUSY) && !mem_ready),
      .o_expired (w_expired)
   );

   assign w_grant_fetch = i_req && (!d_req || (r_starve >= c_STARVE_MAX));
   assign w_finish      = mem_ready || w_expired;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_FETCH;
         r_starve    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_i_err     <= 1'b0;
         r_d_err     <= 1'b0;
      end else begin
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  r_state   <= ST_BUSY;
                  r_mem_req <= 1'b1;
                  if (w_grant_fetch) begin
                     r_owner     <= OWN_FETCH;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= i_addr;
                     r_mem_wdata <= '0;
                     r_starve    <= '0;
                  end else begin
                     r_owner     <= OWN_DATA;
                     r_mem_we    <= d_we;
                     r_mem_addr  <= d_addr;
                     r_mem_wdata <= d_we ? d_wdata : '0;
                     if (i_req && (r_starve < c_STARVE_MAX))
                        r_starve <= r_starve + SW'(1);
                  end
               end
            end
            ST_BUSY: begin
               // A ready arriving in the expiry cycle completes normally.
               if (w_finish) begin
                  r_state   <= ST_RESP;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  if (r_owner == OWN_FETCH) begin
                     r_i_done  <= 1'b1;
                     r_i_rdata <= mem_ready ? mem_rdata : '0;
                     r_i_err   <= mem_ready ? mem_err : 1'b1;
                  end else begin
                     r_d_done  <= 1'b1;
                     r_d_rdata <= (mem_ready && !r_mem_we) ? mem_rdata : '0;
                     r_d_err   <= mem_ready ? mem_err : 1'b1;
                  end
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign i_done    = r_i_done;
   assign i_rdata   = r_i_rdata;
   assign i_err     = r_i_err;
   assign d_done    = r_d_done;
   assign d_rdata   = r_d_rdata;
   assign d_err     = r_d_err;
   assign i_wait    = i_req && !r_i_done && !rst;
   assign d_wait    = d_req && !r_d_done && !rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Transaction-level self-checking bench for mem_port_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW         = 64;
   localparam int DW         = 64;
   localparam int TIMEOUT    = 16;
   localparam int STARVE_MAX = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          i_err, i_wait;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          d_err, d_wait;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_err = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: what each requester last received, and fetch loss streak.
   logic [DW-1:0] e_irdata = '0, e_drdata = '0;
   logic          e_ierr = 1'b0, e_derr = 1'b0;
   int            starve = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err), .i_wait(i_wait),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
      .d_rdata(d_rdata), .d_err(d_err), .d_wait(d_wait),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic chk_held();
      chk("i_rdata_hold", i_rdata, e_irdata);
      chk("i_err_hold",   i_err,   e_ierr);
      chk("d_rdata_hold", d_rdata, e_drdata);
      chk("d_err_hold",   d_err,   e_derr);
   endtask

   // Called at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
   task automatic do_txn(input bit ir, input bit dr, input bit we, input logic [63:0] ia,
                         input logic [63:0] da, input logic [63:0] wd, input int lat,
                         input bit merr, input logic [63:0] rd);
      bit            fw, to, e_we;
      int            n_busy;
      logic [63:0]   e_addr, e_wd;
      i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom}; mem_err = 1'($urandom_range(0, 1));
      #1;
      chk("idle_mem_req", mem_req, 0);
      chk("idle_i_done", i_done, 0);
      chk("idle_d_done", d_done, 0);
      chk("idle_i_wait", i_wait, ir);
      chk("idle_d_wait", d_wait, dr);
      chk_held();
      if (!ir && !dr) begin
         @(posedge clk); #1;
         return;
      end
      fw = ir && (!dr || starve >= STARVE_MAX);
      if (fw) starve = 0;
      else if (ir) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      e_we   = !fw && we;
      e_addr = fw ? ia : da;
      e_wd   = e_we ? wd : 64'd0;
      to     = (lat >= TIMEOUT);
      n_busy = to ? TIMEOUT : lat + 1;
      for (int k = 0; k < n_busy; k++) begin
         @(posedge clk); #1;
         chk("busy_mem_req", mem_req, 1);
         chk("busy_mem_we", mem_we, e_we);
         chk("busy_mem_addr", mem_addr, e_addr);
         chk("busy_mem_wdata", mem_wdata, e_wd);
         chk("busy_i_done", i_done, 0);
         chk("busy_d_done", d_done, 0);
         mem_ready = (k == lat);
         mem_rdata = (k == lat) ? rd : {$urandom, $urandom};
         mem_err   = (k == lat) ? merr : 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (fw) begin
         e_irdata = to ? 64'd0 : rd;
         e_ierr   = to ? 1'b1 : merr;
      end else begin
         e_drdata = (to || we) ? 64'd0 : rd;
         e_derr   = to ? 1'b1 : merr;
      end
      mem_ready = 1'($urandom_range(0, 1));
      chk("resp_mem_req", mem_req, 0);
      chk("resp_i_done", i_done, fw);
      chk("resp_d_done", d_done, !fw);
      chk("resp_i_wait", i_wait, ir && !fw);
      chk("resp_d_wait", d_wait, dr && fw);
      chk_held();
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, with requests high to confirm the waits are gated.
      i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_done", i_done, 0);
      chk("rst_d_done", d_done, 0);
      chk("rst_i_wait", i_wait, 0);
      chk("rst_d_wait", d_wait, 0);
      chk_held();
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;

      // Single fetch, contention, then the starved fetch run.
      do_txn(1, 0, 0, 64'h40, 64'h0, 64'h0, 0, 0, 64'h1122334455667788);
      do_txn(1, 1, 1, 64'h80, 64'h100, 64'hAB, 0, 0, 64'hDEAD);
      do_txn(1, 0, 0, 64'h80, 64'h0, 64'h0, 1, 0, 64'h5555);
      for (int i = 0; i < 6; i++)
         do_txn(1, 1, 0, 64'hC0, 64'h200 + 64'(i * 8), 64'h0, i % 3, 0, 64'(i) + 64'h900);
      // Timeout, ready in the expiry cycle, then a faulted read followed by a clean one.
      do_txn(1, 0, 0, 64'h44, 64'h0, 64'h0, 100, 0, 64'h7777);
      do_txn(0, 1, 0, 64'h0, 64'h48, 64'h0, TIMEOUT - 1, 0, 64'h8888);
      do_txn(0, 1, 0, 64'h0, 64'h50, 64'h0, 2, 1, 64'h9999);
      do_txn(0, 1, 0, 64'h0, 64'h58, 64'h0, 0, 0, 64'hAAAA);

      // Reset in the third BUSY cycle of a fetch.
      i_req = 1'b1; i_addr = 64'h300; d_req = 1'b0; mem_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_mem_req", mem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      e_irdata = '0; e_ierr = 1'b0; e_drdata = '0; e_derr = 1'b0; starve = 0;
      chk("midrst_mem_req", mem_req, 0);
      chk("midrst_i_done", i_done, 0);
      chk("midrst_i_wait", i_wait, 0);
      chk_held();
      rst = 1'b0;
      do_txn(1, 0, 0, 64'h308, 64'h0, 64'h0, 1, 0, 64'h0123456789ABCDEF);

      for (int n = 0; n < 150; n++) begin
         int lat;
         lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT + 1))
                                           : int'($urandom_range(0, 3));
         do_txn($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, lat,
                $urandom_range(0, 5) == 0, {$urandom, $urandom});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's fetch stage and memory stage. Each requester uses a req/done handshake; the block grants one transaction at a time and drives a variable-latency memory port with a timeout. It returns read data and an error flag to the winner. The requester-side wait signals feed the pipeline control unit as extra stall sources.

## Interface
- ADDR_W, 64, byte address width
- DATA_W, 64, data word width
- TIMEOUT, 16, BUSY cycles without mem_ready before the transaction is aborted (≥1)
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins a tie

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch read request; held high with stable i_addr until i_done
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  one-cycle pulse; i_rdata/i_err valid
- i_rdata  out  DATA_W  fetch read data
- i_err  out  1  fetch transaction failed (mem_err or timeout)
- i_wait  out  1  i_req & ~i_done; fetch stall source
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_done  out  1  one-cycle pulse
- d_rdata  out  DATA_W  read data (0 for writes)
- d_err  out  1  data transaction failed
- d_wait  out  1  d_req & ~d_done; memory-stage stall source
- mem_req  out  1  memory transaction active
- mem_we  out  1  write strobe qualifier
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_ready  in  1  memory completes the current access this cycle (sampled only while mem_req)
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_err  in  1  access fault, valid with mem_ready

## Operation
- FSM states: IDLE, BUSY, RESP. `owner` register: FETCH/DATA.
- IDLE: if any req is high, grant and latch addr/we/wdata into mem_* registers, set mem_req=1, clear the timer, and go to BUSY. If no req, stay.
- Arbitration: d_req wins over i_req, unless starve_cnt ≥ STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) when both requests are high and data wins.
  - Clears when fetch is granted.
  - Unchanged otherwise.
- BUSY, when mem_ready=1:
  - Capture mem_rdata into the owner's rdata; d_rdata=0 if the owner was a write.
  - Capture mem_err into the owner's err.
  - Drop mem_req and go to RESP.
- BUSY, when mem_ready=0: timer++. When timer reaches TIMEOUT-1 with no ready, set err=1 and rdata=0, drop mem_req, and go to RESP.
- RESP: pulse the owner's done for exactly one cycle, ignore both reqs, and go to IDLE. Requesters deassert or re-present their request after seeing done.
- Non-owner done/err/rdata are unchanged. rdata/err hold their value until the next transaction of that port.
- mem_we is 1 only for a DATA owner with d_we=1. mem_wdata is 0 for reads.
- A req that drops while not granted is simply not served (a pipeline flush of fetch). A req that drops after grant does not abort the transaction; done still pulses.

## Timing
- Reset: state=IDLE, owner=FETCH, starve_cnt=0, timer=0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata, i_err, d_err, i_wait, d_wait (req gated by rst).
- Reset mid-BUSY aborts. mem_req is low in the cycle after the reset edge and no done pulse is issued.
- Minimum latency (mem_ready in the first BUSY cycle): req seen in IDLE at cycle 0, BUSY at cycle 1, done at cycle 2.
- Throughput: one transaction per 3 cycles minimum.
- mem_ready is ignored outside BUSY.
- i_wait/d_wait are the only combinational outputs. All others are registered.
- Simultaneous mem_ready and timeout expiry: mem_ready wins and no timeout error is raised.

## Structure
- Package y86_mem_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - owner enum {FETCH, DATA}
  - ADDR_W/DATA_W defaults
  - timer width = $clog2(TIMEOUT+1)
- Sub-module mem_timeout_ctr: clear/enable counter with `expired` output, parameterised by TIMEOUT.
- The arbiter FSM and the starvation counter stay in the top.

## Test plan
- Single fetch: i_req=1, i_addr=0x40, mem_ready=1 in the first BUSY cycle with mem_rdata=0x1122334455667788 -> i_done at cycle 2, i_rdata=0x1122334455667788, i_err=0, mem_we=0.
- Contention: i_req and d_req (write, addr 0x100, wdata 0xAB) high together -> data granted first with mem_we=1; fetch served on the next IDLE; d_rdata=0.
- Starvation: d_req held continuously with i_req=1 and STARVE_MAX=4 -> four data grants, then fetch is granted on the 5th arbitration and starve_cnt returns to 0.
- Timeout: TIMEOUT=16, mem_ready held at 0 -> mem_req drops after 16 BUSY cycles; done pulses with err=1, rdata=0.
- mem_err=1 with mem_ready on a data read -> d_done with d_err=1; the next clean read clears d_err.
- Reset asserted in the 3rd BUSY cycle -> next cycle mem_req=0, state IDLE, no done pulse; a new i_req is then served normally.
